// File: rtl/sha_stream_core.sv
// Streaming SHA-0/SHA-1 engine with internal padding; 81 cycles per block (41 with SHA_ROUND2_EN).
// in_ready is high only while filling a block with message bytes left; the producer holds beats otherwise.
module sha_stream_core #(
  parameter int IN_BYTES = 1,
  parameter int LEN_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [LEN_W-1:0]      msg_len,
  input  logic                  in_valid,
  input  logic [8*IN_BYTES-1:0] in_data,
  output logic                  in_ready,
  output logic                  busy,
  output logic                  digest_valid,
  output logic [159:0]          digest
);
`ifdef SHA_ROUND2_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam logic [6:0]   T_LAST = 7'(80 - STEP);
  localparam logic [159:0] H_INIT = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;

  typedef enum logic [2:0] {IDLE, LOAD, PAD, ROUND, ADD, DONE} state_t;
  state_t state, state_n;

  logic             mode_r, need_80, len_done, accept, pad_fits;
  logic [LEN_W-1:0] len_r, rem, take;
  logic [6:0]       fill, t;
  logic [511:0]     blk, blk_load, blk_pad, blk_sched;
  logic [159:0]     h, work, work_n, h_sum;
  logic [63:0]      bit_len;

  function automatic logic [31:0] wrd(input logic [511:0] v, input int i);
    return v[511-32*i -: 32];
  endfunction

  // The block buffer is a 16-word window sliding over W[t..t+15].
  function automatic logic [31:0] next_w(input logic [511:0] v, input int i, input logic sha1);
    logic [31:0] x;
    x = wrd(v, i + 13) ^ wrd(v, i + 8) ^ wrd(v, i + 2) ^ wrd(v, i);
    return sha1 ? {x[30:0], x[31]} : x;
  endfunction

  function automatic logic [159:0] sha_round(input logic [159:0] s, input logic [31:0] w,
                                             input logic [6:0] tt);
    logic [31:0] a, b, c, d, e, f, k;
    {a, b, c, d, e} = s;
    if (tt < 7'd20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
    else if (tt < 7'd40) begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
    else if (tt < 7'd60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
    else                 begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
    return {{a[26:0], a[31:27]} + f + e + k + w, a, {b[1:0], b[31:2]}, c, d};
  endfunction

  assign in_ready     = (state == LOAD) && (rem != '0) && (fill != 7'd64);
  assign accept       = in_ready && in_valid;
  assign busy         = (state != IDLE);
  assign digest_valid = (state == DONE);
  assign take         = (rem < LEN_W'(IN_BYTES)) ? rem : LEN_W'(IN_BYTES);
  assign bit_len      = 64'({len_r, 3'b000});
  assign pad_fits     = (fill + {6'd0, need_80}) <= 7'd56;
  assign h_sum        = {h[159:128] + work[159:128], h[127:96] + work[127:96],
                         h[95:64] + work[95:64], h[63:32] + work[63:32], h[31:0] + work[31:0]};

  always_comb begin
    work_n    = sha_round(work, wrd(blk, 0), t);
    blk_sched = {blk[479:0], next_w(blk, 0, mode_r)};
`ifdef SHA_ROUND2_EN
    work_n    = sha_round(work_n, wrd(blk, 1), t + 7'd1);
    blk_sched = {blk[447:0], next_w(blk, 0, mode_r), next_w(blk, 1, mode_r)};
`endif
  end

  // Only the first 'take' bytes of a beat (MSB first) land in the buffer.
  always_comb begin
    blk_load = blk;
    for (int k = 0; k < IN_BYTES; k++)
      if (accept && (LEN_W'(k) < take))
        blk_load[511 - 8*(int'(fill) + k) -: 8] = in_data[8*IN_BYTES-1-8*k -: 8];
  end

  always_comb begin
    blk_pad = blk;
    for (int p = 0; p < 64; p++)
      if (7'(p) >= fill)
        blk_pad[511-8*p -: 8] = ((7'(p) == fill) && need_80) ? 8'h80 : 8'h00;
    if (pad_fits) blk_pad[63:0] = bit_len;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (start) state_n = LOAD;
      LOAD:  begin
        if (accept) begin
          if (fill + take[6:0] == 7'd64) state_n = ROUND;
          else if (rem == take)          state_n = PAD;
        end else if (rem == '0) begin
          state_n = PAD;
        end
      end
      PAD:   state_n = ROUND;
      ROUND: if (t == T_LAST) state_n = ADD;
      ADD:   begin
        if (rem != '0)     state_n = LOAD;
        else if (!len_done) state_n = PAD;
        else               state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mode_r   <= 1'b0;
      need_80  <= 1'b0;
      len_done <= 1'b0;
      len_r    <= '0;
      rem      <= '0;
      fill     <= '0;
      t        <= '0;
      blk      <= '0;
      h        <= '0;
      work     <= '0;
      digest   <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (start) begin
          mode_r   <= mode;
          len_r    <= msg_len;
          rem      <= msg_len;
          fill     <= '0;
          need_80  <= 1'b1;
          len_done <= 1'b0;
          h        <= H_INIT;
        end
        LOAD: begin
          work <= h;
          t    <= '0;
          if (accept) begin
            blk  <= blk_load;
            fill <= fill + take[6:0];
            rem  <= rem - take;
          end
        end
        PAD: begin
          blk      <= blk_pad;
          work     <= h;
          t        <= '0;
          need_80  <= 1'b0;
          len_done <= pad_fits;
        end
        ROUND: begin
          work <= work_n;
          blk  <= blk_sched;
          t    <= t + 7'(STEP);
        end
        ADD: begin
          h    <= h_sum;
          fill <= '0;
          if (state_n == DONE) digest <= h_sum;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sha_stream_core.sv
// Directed bench for sha_stream_core: one 1-byte-beat and one 4-byte-beat instance, known digests.
`timescale 1ns/1ps
module tb_sha_stream_core;
  localparam int LEN_W = 16;
`ifdef SHA_ROUND2_EN
  localparam int LAT = 43;
`else
  localparam int LAT = 83;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             start1, start4, mode, sel, in_valid;
  logic [LEN_W-1:0] msg_len;
  logic [7:0]       in_data1;
  logic [31:0]      in_data4;
  logic             in_ready1, busy1, dv1, in_ready4, busy4, dv4;
  logic [159:0]     digest1, digest4;
  logic             cur_rdy, cur_busy, cur_dv;
  logic [159:0]     cur_dig;

  sha_stream_core #(.IN_BYTES(1), .LEN_W(LEN_W)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode), .msg_len(msg_len),
    .in_valid(in_valid), .in_data(in_data1), .in_ready(in_ready1), .busy(busy1),
    .digest_valid(dv1), .digest(digest1));

  sha_stream_core #(.IN_BYTES(4), .LEN_W(LEN_W)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode), .msg_len(msg_len),
    .in_valid(in_valid), .in_data(in_data4), .in_ready(in_ready4), .busy(busy4),
    .digest_valid(dv4), .digest(digest4));

  assign cur_rdy  = sel ? in_ready4 : in_ready1;
  assign cur_busy = sel ? busy4 : busy1;
  assign cur_dv   = sel ? dv4 : dv1;
  assign cur_dig  = sel ? digest4 : digest1;

  int passed = 0, fails = 0, total = 0;
  logic [7:0]   msg [0:127];
  int           n;
  logic [159:0] prev1 = '0, prev4 = '0;
  int           acc_c, dv_c, idx;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bytes past the message are 0xee so a core that reads beyond msg_len corrupts the digest.
  task automatic set_msg(input string s);
    n = s.len();
    for (int i = 0; i < 128; i++) msg[i] = (i < n) ? s[i] : 8'hee;
  endtask

  task automatic drive_beat(input int i);
    in_data1 = msg[i];
    in_data4 = {msg[i], msg[i+1], msg[i+2], msg[i+3]};
  endtask

  task automatic run_hash(input bit which, input logic md, input int gap, input bit extra,
                          input logic [159:0] exp, input string tag,
                          output int acc_cyc, output int dv_cyc);
    int cyc, w, cnt;
    logic [159:0] prev;
    w    = which ? 4 : 1;
    prev = which ? prev4 : prev1;
    sel  = which;
    @(negedge clk);
    mode    = md;
    msg_len = LEN_W'(n);
    if (which) start4 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1  = 1'b0;
    start4  = 1'b0;
    mode    = ~md;
    msg_len = '1;
    check({tag, " busy_after_start"}, 160'(cur_busy), 160'(1));
    check({tag, " digest_hold"}, cur_dig, prev);
    cnt = 0; cyc = 0; acc_cyc = -1;
    while (cyc < 2000 && !cur_dv) begin
      in_valid = ($urandom_range(99) >= gap);
      drive_beat(cnt);
      if (in_valid && cur_rdy) begin
        cnt += w;
        acc_cyc = cyc;
      end
      if (extra && cyc == 60) begin
        if (which) start4 = 1'b1; else start1 = 1'b1;
      end else begin
        start1 = 1'b0;
        start4 = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start1 = 1'b0;
    start4 = 1'b0;
    dv_cyc = cyc;
    check({tag, " digest_valid"}, 160'(cur_dv), 160'(1));
    check({tag, " digest"}, cur_dig, exp);
    check({tag, " busy_at_dv"}, 160'(cur_busy), 160'(1));
    check({tag, " bytes_taken"}, 160'(cnt), 160'(((n + w - 1) / w) * w));
    in_valid = 1'b1;
    @(negedge clk);
    check({tag, " idle_after"}, 160'({cur_busy, cur_dv, cur_rdy}), 160'(0));
    check({tag, " digest_kept"}, cur_dig, exp);
    in_valid = 1'b0;
    if (which) prev4 = exp; else prev1 = exp;
  endtask

  initial begin
    start1 = 0; start4 = 0; mode = 0; msg_len = '0; in_valid = 0; sel = 0;
    set_msg("");
    drive_beat(0);
    repeat (3) @(negedge clk);
    check("reset dut1", {in_ready1, busy1, dv1, digest1[156:0]}, '0);
    check("reset dut4", {in_ready4, busy4, dv4, digest4[156:0]}, '0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset dut1 digest", digest1, '0);
    check("post_reset dut1 ctrl", 160'({in_ready1, busy1, dv1}), '0);

    set_msg("");
    run_hash(0, 1'b0, 30, 1'b0, 160'hf96cea19_8ad1dd56_17ac084a_3d92c610_7708c0ef,
             "sha0_empty", acc_c, dv_c);
    set_msg("abc");
    run_hash(0, 1'b1, 30, 1'b0, 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d,
             "sha1_abc_b1", acc_c, dv_c);
    run_hash(1, 1'b1, 0, 1'b0, 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d,
             "sha1_abc_b4", acc_c, dv_c);
    run_hash(1, 1'b0, 25, 1'b0, 160'h0164b8a9_14cd2a5e_74c4f7ff_082c4d97_f1edf880,
             "sha0_abc_b4", acc_c, dv_c);
    set_msg("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
    run_hash(1, 1'b1, 20, 1'b0, 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1,
             "sha1_448_b4", acc_c, dv_c);
    set_msg("message digest");
    run_hash(0, 1'b0, 40, 1'b1, 160'hc1b0f222_d150ebb9_aa36a40c_afdc8bcb_ed830b14,
             "sha0_md_gaps", acc_c, dv_c);

    // Reset in the middle of a SHA-1 block.
    set_msg("abc");
    sel = 0;
    @(negedge clk);
    mode = 1'b1; msg_len = 16'd3; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    idx = 0;
    for (int c = 0; c < 10 && idx < 3; c++) begin
      in_valid = 1'b1;
      drive_beat(idx);
      if (in_ready1) idx++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (30) @(negedge clk);
    check("midround busy", 160'(busy1), 160'(1));
    rst = 1'b1;
    #1;
    check("rst dut1 digest", digest1, '0);
    check("rst dut1 ctrl", 160'({in_ready1, busy1, dv1}), '0);
    check("rst dut4 digest", digest4, '0);
    prev1 = '0;
    prev4 = '0;
    @(negedge clk);
    rst = 1'b0;

    set_msg("");
    run_hash(0, 1'b1, 0, 1'b0, 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709,
             "sha1_empty", acc_c, dv_c);
    set_msg("abc");
    run_hash(0, 1'b1, 0, 1'b0, 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d,
             "latency_abc", acc_c, dv_c);
    check("latency accept_to_dv", 160'(dv_c - acc_c), 160'(LAT));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
